oam_dma: RTL and testbench
==========================

Name: oam_dma

Overview:
- Game Boy OAM DMA engine (register FF46), sitting directly upstream of the work/cartridge RAM.
- The CPU writes a source page; the block then drives the 8K RAM's cs/oe/addr to read 160 bytes from page<<8.
- It writes those bytes into OAM at 0x00..0x9F.
- It holds the CPU off the bus while busy.

Parameters:
- CYCLES_PER_BYTE, 4, clocks per transferred byte (one M-cycle); legal range >= 3.
- START_DELAY, 4, clocks between the register write and the first source read.
- NUM_BYTES, 160, bytes per transfer (OAM size).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- reg_wr  input  1  one-cycle strobe; CPU write to FF46.
- reg_wdata  input  8  source page written by the CPU.
- reg_rdata  output  8  last page written (FF46 readback).
- busy  output  1  high from the cycle after reg_wr until the last OAM write completes.
- cpu_block  output  1  equals busy; the CPU bus arbiter stalls non-HRAM accesses.
- src_addr  output  16  source byte address, {page, idx}.
- src_cs  output  1  RAM chip select.
- src_oe  output  1  RAM output enable.
- src_we  output  1  tied 0; the block never writes the source.
- src_rdata  input  8  RAM read data; valid one cycle after the cs/oe cycle (registered RAM).
- oam_addr  output  8  OAM write address.
- oam_wdata  output  8  OAM write data.
- oam_we  output  1  OAM write strobe, one cycle per byte.

Behaviour:
- All outputs are registered. Reset values:
  - busy = 0, cpu_block = 0.
  - src_addr = 0, src_cs = 0, src_oe = 0, src_we = 0.
  - oam_addr = 0, oam_wdata = 0, oam_we = 0.
  - reg_rdata = 0xFF.
- Reset has priority over everything. Reset mid-transfer aborts it immediately; no further OAM writes occur.
- States:
  - IDLE: waits for reg_wr.
  - START: delay counter runs START_DELAY cycles, then go to XFER.
  - XFER: byte counter idx 0..NUM_BYTES-1; phase counter ph 0..CYCLES_PER_BYTE-1.
- Within XFER, per byte:
  - ph 0: src_cs = src_oe = 1; src_addr = {page, idx}.
  - ph 1: cs/oe drop to 0; src_rdata is sampled at the end of ph 1 into oam_wdata; oam_addr = idx.
  - ph 2: oam_we = 1 for exactly one cycle.
  - ph 3..CYCLES_PER_BYTE-1: idle.
- After the final phase of idx = NUM_BYTES-1, return to IDLE and clear busy/cpu_block on the same edge.
- Total busy length = START_DELAY + NUM_BYTES*CYCLES_PER_BYTE cycles (644 at defaults).
- reg_wr in IDLE:
  - Latch page = reg_wdata and reg_rdata = reg_wdata.
  - busy = 1 on the next edge; enter START.
- reg_wr while busy (restart):
  - Abort the current byte; any pending oam_we in the same cycle is suppressed.
  - Latch the new page, clear idx/ph, re-enter START. busy stays high continuously.
- reg_wr coincident with the final byte's last phase: restart wins; busy never drops.
- idx never exceeds NUM_BYTES-1; there is no wrap into oam_addr >= 0xA0.
- oam_addr and src_addr low byte hold their last values when idle.
- src_addr upper byte = page, except as modified by the optional feature.

Optional Feature:
- Macro: OAM_DMA_ECHO_MIRROR_EN.
- Defined: source pages 0xE0..0xFF map to page - 0x20 (0xC0..0xDF, the WRAM echo) on src_addr[15:8]. reg_rdata still returns the unmodified written value.
- Undefined: src_addr[15:8] = page verbatim for all pages.

Test Plan:
- Basic transfer: RAM 0xC100..0xC19F preloaded with idx^0x5A; reg_wr with 0xC1 -> busy for exactly 644 cycles; 160 oam_we pulses spaced 4 cycles apart; OAM[i] == i^0x5A; reg_rdata = 0xC1.
- Timing/handshake: check the first src_cs at 4 cycles after reg_wr, the first oam_we 2 cycles after that with oam_addr = 0x00, and the last oam_we with oam_addr = 0x9F. src_we is 0 throughout.
- Restart: reg_wr 0xC1, then reg_wr 0xC3 at byte 50 -> busy stays high; no further writes from page C1; 160 writes from 0xC300 follow; total busy = 644 cycles counted from the second write.
- Reset mid-transfer: assert rst at byte 80 for 1 cycle -> all outputs at reset values on the next edge; reg_rdata = 0xFF; no oam_we afterwards.
- Echo page: reg_wr 0xE2 -> src_addr[15:8] = 0xC2 with OAM_DMA_ECHO_MIRROR_EN, 0xE2 without; reg_rdata = 0xE2 in both builds.
- Parameter corner: CYCLES_PER_BYTE=3, START_DELAY=0 -> busy = 480 cycles; oam_we every 3 cycles; data correct.

Source files
------------

// File: rtl/oam_dma_if.sv
// Bus bundle for the OAM DMA engine: CPU register port, source RAM port and OAM write port.
// The master modport is the DMA engine; the slave modport is the surrounding system.
interface oam_dma_if;
  logic        reg_wr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        busy;
  logic        cpu_block;
  logic [15:0] src_addr;
  logic        src_cs;
  logic        src_oe;
  logic        src_we;
  logic [7:0]  src_rdata;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;

  modport master (
    input  reg_wr, reg_wdata, src_rdata,
    output reg_rdata, busy, cpu_block, src_addr, src_cs, src_oe, src_we,
           oam_addr, oam_wdata, oam_we
  );

  modport slave (
    output reg_wr, reg_wdata, src_rdata,
    input  reg_rdata, busy, cpu_block, src_addr, src_cs, src_oe, src_we,
           oam_addr, oam_wdata, oam_we
  );
endinterface

// File: rtl/oam_dma.sv
// Game Boy OAM DMA engine (FF46): copies NUM_BYTES from {page, idx} into OAM 0x00..NUM_BYTES-1.
// Optional macro OAM_DMA_ECHO_MIRROR_EN folds source pages 0xE0..0xFF onto the WRAM echo 0xC0..0xDF.
module oam_dma #(
  parameter int CYCLES_PER_BYTE = 4,
  parameter int START_DELAY     = 4,
  parameter int NUM_BYTES       = 160
) (
  input logic       clk,
  input logic       rst,
  oam_dma_if.master bus
);
  localparam int PH_W     = $clog2(CYCLES_PER_BYTE);
  localparam int DLY_W    = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam int DLY_LAST = (START_DELAY > 0) ? START_DELAY - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_START, S_XFER} state_t;

  state_t           state_q, state_d;
  logic [7:0]       idx_q, idx_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [7:0]       page_q, page_d;

  logic        busy_q, busy_d;
  logic        blk_q;
  logic [15:0] src_addr_q, src_addr_d;
  logic        src_cs_q, src_cs_d;
  logic        src_oe_q;
  logic [7:0]  oam_addr_q, oam_addr_d;
  logic [7:0]  oam_wdata_q, oam_wdata_d;
  logic        oam_we_q, oam_we_d;

  function automatic logic [7:0] src_page(input logic [7:0] p);
`ifdef OAM_DMA_ECHO_MIRROR_EN
    if (p >= 8'hE0) return p - 8'h20;
    else            return p;
`else
    return p;
`endif
  endfunction

  // A register write always wins, including a restart on the final byte's last phase.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ph_d    = ph_q;
    dly_d   = dly_q;
    page_d  = page_q;
    if (bus.reg_wr) begin
      page_d  = bus.reg_wdata;
      idx_d   = '0;
      ph_d    = '0;
      dly_d   = '0;
      state_d = (START_DELAY == 0) ? S_XFER : S_START;
    end else begin
      unique case (state_q)
        S_START: begin
          if (dly_q == DLY_W'(DLY_LAST)) state_d = S_XFER;
          else                           dly_d   = dly_q + 1'b1;
        end
        S_XFER: begin
          if (ph_q == PH_W'(CYCLES_PER_BYTE - 1)) begin
            ph_d = '0;
            if (idx_q == 8'(NUM_BYTES - 1)) state_d = S_IDLE;
            else                            idx_d   = idx_q + 8'd1;
          end else begin
            ph_d = ph_q + 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Outputs are decoded from the next state so every bus pin comes straight from a flop.
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    src_cs_d    = (state_d == S_XFER) && (ph_d == PH_W'(0));
    src_addr_d  = src_cs_d ? {src_page(page_d), idx_d} : src_addr_q;
    oam_addr_d  = ((state_d == S_XFER) && (ph_d == PH_W'(1))) ? idx_d : oam_addr_q;
    oam_we_d    = (state_d == S_XFER) && (ph_d == PH_W'(2));
    oam_wdata_d = oam_wdata_q;
    if ((state_q == S_XFER) && (ph_q == PH_W'(1)) && !bus.reg_wr)
      oam_wdata_d = bus.src_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      ph_q        <= '0;
      dly_q       <= '0;
      page_q      <= 8'hFF;
      busy_q      <= 1'b0;
      blk_q       <= 1'b0;
      src_addr_q  <= '0;
      src_cs_q    <= 1'b0;
      src_oe_q    <= 1'b0;
      oam_addr_q  <= '0;
      oam_wdata_q <= '0;
      oam_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ph_q        <= ph_d;
      dly_q       <= dly_d;
      page_q      <= page_d;
      busy_q      <= busy_d;
      blk_q       <= busy_d;
      src_addr_q  <= src_addr_d;
      src_cs_q    <= src_cs_d;
      src_oe_q    <= src_cs_d;
      oam_addr_q  <= oam_addr_d;
      oam_wdata_q <= oam_wdata_d;
      oam_we_q    <= oam_we_d;
    end
  end

  assign bus.reg_rdata = page_q;
  assign bus.busy      = busy_q;
  assign bus.cpu_block = blk_q;
  assign bus.src_addr  = src_addr_q;
  assign bus.src_cs    = src_cs_q;
  assign bus.src_oe    = src_oe_q;
  assign bus.src_we    = 1'b0;
  assign bus.oam_addr  = oam_addr_q;
  assign bus.oam_wdata = oam_wdata_q;
  assign bus.oam_we    = oam_we_q;
endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: default instance plus a CYCLES_PER_BYTE=3 / START_DELAY=0 instance.
module tb_oam_dma;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   side_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  oam_dma_if bus0();
  oam_dma_if bus3();

  oam_dma u_dut (.clk(clk), .rst(rst), .bus(bus0));
  oam_dma #(.CYCLES_PER_BYTE(3), .START_DELAY(0), .NUM_BYTES(160)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  logic [7:0] mem [65536];
  logic [7:0] rd0, rd3;

  // Registered RAM: data appears the cycle after cs/oe, garbage otherwise.
  always @(posedge clk) begin
    if (bus0.src_cs && bus0.src_oe) rd0 <= mem[bus0.src_addr];
    else                            rd0 <= 8'($urandom);
    if (bus3.src_cs && bus3.src_oe) rd3 <= mem[bus3.src_addr];
    else                            rd3 <= 8'($urandom);
  end
  assign bus0.src_rdata = rd0;
  assign bus3.src_rdata = rd3;

  int          we_cyc[$];
  logic [7:0]  we_addr[$];
  logic [7:0]  we_data[$];
  int          cs_cyc[$];
  logic [15:0] cs_addr[$];
  int          we3_cyc[$];
  logic [7:0]  we3_addr[$];
  logic [7:0]  we3_data[$];
  int          cs3_cyc[$];

  always @(posedge clk) begin
    #1;
    if (bus0.oam_we) begin
      we_cyc.push_back(cyc); we_addr.push_back(bus0.oam_addr); we_data.push_back(bus0.oam_wdata);
    end
    if (bus0.src_cs) begin
      cs_cyc.push_back(cyc); cs_addr.push_back(bus0.src_addr);
    end
    if (bus3.oam_we) begin
      we3_cyc.push_back(cyc); we3_addr.push_back(bus3.oam_addr); we3_data.push_back(bus3.oam_wdata);
    end
    if (bus3.src_cs) cs3_cyc.push_back(cyc);
    if (bus0.src_oe !== bus0.src_cs || bus0.src_we !== 1'b0 || bus3.src_oe !== bus3.src_cs || bus3.src_we !== 1'b0)
      side_bad++;
  end

  function automatic logic [7:0] eff_page(input logic [7:0] p);
`ifdef OAM_DMA_ECHO_MIRROR_EN
    if (p >= 8'hE0) return p - 8'h20;
`endif
    return p;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [7:0] p, input int i);
    return mem[{eff_page(p), 8'(i)}];
  endfunction

  task automatic clear_logs();
    we_cyc.delete(); we_addr.delete(); we_data.delete(); cs_cyc.delete(); cs_addr.delete();
    we3_cyc.delete(); we3_addr.delete(); we3_data.delete(); cs3_cyc.delete();
  endtask

  task automatic do_write(input logic [7:0] p, output int w);
    @(negedge clk);
    bus0.reg_wr = 1'b1; bus0.reg_wdata = p;
    @(negedge clk);
    bus0.reg_wr = 1'b0; bus0.reg_wdata = 8'($urandom);
    w = cyc;
  endtask

  // Counts busy cycles from the current negedge until busy drops (bounded).
  task automatic wait_idle0(output int len, output int blk_bad);
    len = 0; blk_bad = 0;
    for (int k = 0; k < 2000; k++) begin
      if (!bus0.busy) return;
      if (bus0.cpu_block !== bus0.busy) blk_bad++;
      len++;
      @(negedge clk);
    end
    errors++;
    $display("FAIL busy_timeout: busy still high after %0d cycles, required to drop", len);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus0.reg_wr = 1'b0; bus0.reg_wdata = 8'h00;
    bus3.reg_wr = 1'b0; bus3.reg_wdata = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus0.busy, bus0.cpu_block, bus0.src_addr, bus0.src_cs, bus0.src_oe, bus0.src_we,
         bus0.oam_addr, bus0.oam_wdata, bus0.oam_we} !== 45'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b blk=%b sa=%h cs=%b oe=%b we=%b oa=%h od=%h owe=%b, required all 0",
               bus0.busy, bus0.cpu_block, bus0.src_addr, bus0.src_cs, bus0.src_oe, bus0.src_we,
               bus0.oam_addr, bus0.oam_wdata, bus0.oam_we);
    end
    checks++;
    if (bus0.reg_rdata !== 8'hFF) begin
      errors++; $display("FAIL reset_rdata: got %h required ff", bus0.reg_rdata);
    end
    checks++;
    if (bus3.busy !== 1'b0 || bus3.reg_rdata !== 8'hFF) begin
      errors++; $display("FAIL reset_dut3: busy=%b rdata=%h required 0/ff", bus3.busy, bus3.reg_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int w, len, blk_bad;
    clear_logs();
    do_write(8'hC1, w);
    wait_idle0(len, blk_bad);
    checks++;
    if (len != 644) begin errors++; $display("FAIL basic_busy_len: got %0d required 644", len); end
    checks++;
    if (blk_bad != 0) begin errors++; $display("FAIL basic_cpu_block: %0d cycles differ from busy, required 0", blk_bad); end
    checks++;
    if (bus0.reg_rdata !== 8'hC1) begin errors++; $display("FAIL basic_rdata: got %h required c1", bus0.reg_rdata); end
    checks++;
    if (we_cyc.size() != 160) begin errors++; $display("FAIL basic_we_count: got %0d required 160", we_cyc.size()); end
    checks++;
    if (cs_cyc.size() != 160) begin errors++; $display("FAIL basic_cs_count: got %0d required 160", cs_cyc.size()); end
    checks++;
    if (cs_cyc.size() == 0 || cs_cyc[0] != w + 4) begin
      errors++; $display("FAIL basic_first_cs: got cycle %0d required %0d", cs_cyc.size() ? cs_cyc[0] : -1, w + 4);
    end
    for (int i = 0; i < 160 && i < we_cyc.size() && i < cs_cyc.size(); i++) begin
      checks++;
      if (we_cyc[i] != w + 6 + 4 * i || we_addr[i] !== 8'(i) || we_data[i] !== (8'(i) ^ 8'h5A)) begin
        errors++;
        $display("FAIL basic_oam[%0d]: got cyc=%0d addr=%h data=%h required cyc=%0d addr=%h data=%h",
                 i, we_cyc[i], we_addr[i], we_data[i], w + 6 + 4 * i, 8'(i), 8'(i) ^ 8'h5A);
      end
      checks++;
      if (cs_addr[i] !== {8'hC1, 8'(i)}) begin
        errors++; $display("FAIL basic_src_addr[%0d]: got %h required %h", i, cs_addr[i], {8'hC1, 8'(i)});
      end
    end
    checks++;
    if (side_bad != 0) begin errors++; $display("FAIL src_oe_we: %0d bad cycles required 0", side_bad); end
  endtask

  task automatic test_restart();
    int w1, w2, len, blk_bad, drop, pre, bad_cs;
    bit ok;
    clear_logs();
    drop = 0; ok = 0;
    do_write(8'hC1, w1);
    for (int k = 0; k < 400 && !ok; k++) begin
      if (!bus0.busy) drop++;
      if (we_cyc.size() >= 50) ok = 1;
      else @(negedge clk);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL restart_wait50: got %0d writes required 50", we_cyc.size()); end
    do_write(8'hC3, w2);
    wait_idle0(len, blk_bad);
    checks++;
    if (len != 644 || drop != 0) begin
      errors++; $display("FAIL restart_busy: got len=%0d drops=%0d required 644/0", len, drop);
    end
    pre = 0;
    foreach (we_cyc[i]) if (we_cyc[i] <= w2) pre++;
    checks++;
    if (pre != 50 || we_cyc.size() != 210) begin
      errors++; $display("FAIL restart_counts: got pre=%0d total=%0d required 50/210", pre, we_cyc.size());
    end
    for (int k = 0; k < 160 && pre + k < we_cyc.size(); k++) begin
      checks++;
      if (we_cyc[pre + k] != w2 + 6 + 4 * k || we_addr[pre + k] !== 8'(k) || we_data[pre + k] !== ref_byte(8'hC3, k)) begin
        errors++;
        $display("FAIL restart_oam[%0d]: got cyc=%0d addr=%h data=%h required cyc=%0d addr=%h data=%h",
                 k, we_cyc[pre + k], we_addr[pre + k], we_data[pre + k], w2 + 6 + 4 * k, 8'(k), ref_byte(8'hC3, k));
      end
    end
    bad_cs = 0;
    foreach (cs_cyc[i]) if (cs_cyc[i] > w2 && cs_addr[i][15:8] !== 8'hC3) bad_cs++;
    checks++;
    if (bad_cs != 0) begin errors++; $display("FAIL restart_old_page: %0d reads after restart not from c3, required 0", bad_cs); end
  endtask

  task automatic test_reset_mid();
    int w, n;
    bit ok;
    clear_logs();
    ok = 0;
    do_write(8'hC1, w);
    for (int k = 0; k < 500 && !ok; k++) begin
      if (we_cyc.size() >= 80) ok = 1;
      else @(negedge clk);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_wait80: got %0d writes required 80", we_cyc.size()); end
    rst = 1'b1;
    @(negedge clk);
    n = we_cyc.size();
    checks++;
    if ({bus0.busy, bus0.cpu_block, bus0.src_addr, bus0.src_cs, bus0.src_oe, bus0.src_we,
         bus0.oam_addr, bus0.oam_wdata, bus0.oam_we, bus0.reg_rdata} !== {45'd0, 8'hFF}) begin
      errors++;
      $display("FAIL rstmid_outputs: busy=%b sa=%h cs=%b oa=%h od=%h owe=%b rd=%h required 0..0/ff",
               bus0.busy, bus0.src_addr, bus0.src_cs, bus0.oam_addr, bus0.oam_wdata, bus0.oam_we, bus0.reg_rdata);
    end
    rst = 1'b0;
    repeat (60) @(negedge clk);
    checks++;
    if (we_cyc.size() != n || bus0.busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_no_writes: got writes=%0d busy=%b required %0d/0", we_cyc.size(), bus0.busy, n);
    end
  endtask

  task automatic test_echo();
    int w, len, blk_bad, bad;
    clear_logs();
    do_write(8'hE2, w);
    wait_idle0(len, blk_bad);
    checks++;
`ifdef OAM_DMA_ECHO_MIRROR_EN
    if (cs_addr.size() == 0 || cs_addr[0][15:8] !== 8'hC2) begin
      errors++; $display("FAIL echo_page: got %h required c2", cs_addr.size() ? cs_addr[0][15:8] : 8'h00);
    end
`else
    if (cs_addr.size() == 0 || cs_addr[0][15:8] !== 8'hE2) begin
      errors++; $display("FAIL echo_page: got %h required e2", cs_addr.size() ? cs_addr[0][15:8] : 8'h00);
    end
`endif
    checks++;
    if (bus0.reg_rdata !== 8'hE2) begin errors++; $display("FAIL echo_rdata: got %h required e2", bus0.reg_rdata); end
    bad = 0;
    foreach (we_data[i]) if (we_data[i] !== ref_byte(8'hE2, i)) bad++;
    checks++;
    if (bad != 0 || we_data.size() != 160) begin
      errors++; $display("FAIL echo_data: %0d bad of %0d writes, required 0 of 160", bad, we_data.size());
    end
  endtask

  task automatic test_random();
    int w, len, blk_bad, bad;
    logic [7:0] p;
    for (int t = 0; t < 3; t++) begin
      clear_logs();
      p = 8'($urandom_range(0, 255));
      do_write(p, w);
      wait_idle0(len, blk_bad);
      checks++;
      if (len != 644) begin errors++; $display("FAIL rand_busy_len page %h: got %0d required 644", p, len); end
      bad = 0;
      foreach (we_data[i])
        if (we_data[i] !== ref_byte(p, i) || we_addr[i] !== 8'(i) || cs_addr[i] !== {eff_page(p), 8'(i)}) bad++;
      checks++;
      if (bad != 0 || we_data.size() != 160) begin
        errors++; $display("FAIL rand_data page %h: %0d bad of %0d writes, required 0 of 160", p, bad, we_data.size());
      end
    end
  endtask

  task automatic test_param_corner();
    int w, len, bad;
    logic [7:0] p;
    clear_logs();
    p = 8'($urandom_range(0, 255));
    @(negedge clk);
    bus3.reg_wr = 1'b1; bus3.reg_wdata = p;
    @(negedge clk);
    bus3.reg_wr = 1'b0;
    w = cyc;
    len = 0;
    for (int k = 0; k < 1000 && bus3.busy; k++) begin
      len++;
      @(negedge clk);
    end
    checks++;
    if (len != 480) begin errors++; $display("FAIL corner_busy_len: got %0d required 480", len); end
    checks++;
    if (cs3_cyc.size() == 0 || cs3_cyc[0] != w) begin
      errors++; $display("FAIL corner_first_cs: got %0d required %0d", cs3_cyc.size() ? cs3_cyc[0] : -1, w);
    end
    bad = 0;
    foreach (we3_cyc[i])
      if (we3_cyc[i] != w + 2 + 3 * i || we3_addr[i] !== 8'(i) || we3_data[i] !== ref_byte(p, i)) bad++;
    checks++;
    if (bad != 0 || we3_cyc.size() != 160) begin
      errors++; $display("FAIL corner_writes page %h: %0d bad of %0d, required 0 of 160", p, bad, we3_cyc.size());
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 160; i++) mem[16'hC100 + i] = 8'(i) ^ 8'h5A;
    test_reset();
    test_basic();
    test_restart();
    test_reset_mid();
    test_echo();
    test_random();
    test_param_corner();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, required completion before 2 ms");
    $fatal(1);
  end
endmodule
